// File: rtl/ctrl_reg_cond_inc_if.sv
// Bus between the microstore/sequencer side and the control-register slice:
// microinstruction word and conditions in, decoded control fields out.
interface ctrl_reg_cond_inc_if #(
  parameter int ADDR_W = 7,
  parameter int WORD_W = 44
);
  // microstore / sequencer side
  logic [WORD_W-1:0] StateSignals;
  logic              moc;
  logic              cond;
  logic              dmoc;
  logic [ADDR_W-1:0] state_in;

  // decoded control fields
  logic              IRld, PCld, nPCld, RFld;
  logic              MA, MC, ME, MF, MPA, MP, MR;
  logic              RW, MOV, MDRld, MARld;
  logic [1:0]        MB;
  logic [5:0]        OpC;
  logic              Cin;
  logic [1:0]        SSE;
  logic [3:0]        OP;
  logic [ADDR_W-1:0] CR;
  logic              Inv;
  logic              IncRld;
  logic [1:0]        S;
  logic [2:0]        N;
  logic              cond_out;
  logic [ADDR_W-1:0] inc_out;

  modport master (
    output StateSignals, moc, cond, dmoc, state_in,
    input  IRld, PCld, nPCld, RFld, MA, MC, ME, MF, MPA, MP, MR,
           RW, MOV, MDRld, MARld, MB, OpC, Cin, SSE, OP, CR, Inv,
           IncRld, S, N, cond_out, inc_out
  );

  modport slave (
    input  StateSignals, moc, cond, dmoc, state_in,
    output IRld, PCld, nPCld, RFld, MA, MC, ME, MF, MPA, MP, MR,
           RW, MOV, MDRld, MARld, MB, OpC, Cin, SSE, OP, CR, Inv,
           IncRld, S, N, cond_out, inc_out
  );
endinterface

// File: rtl/ctrl_reg_cond_inc.sv
// Control-register slice of the microsequencer: registers the microword,
// slices it into control fields, muxes the branch condition, increments state.
module ctrl_reg_cond_inc #(
  parameter int ADDR_W = 7,
  parameter int WORD_W = 44
) (
  input  logic clk,
  input  logic reset,
  ctrl_reg_cond_inc_if.slave bus
);

  // Field layout of the microword, MSB first; width is pinned by the field map.
  typedef struct packed {
    logic       irld;
    logic       pcld;
    logic       npcld;
    logic       rfld;
    logic       ma;
    logic [1:0] mb;
    logic       mc;
    logic       me;
    logic       mf;
    logic       mpa;
    logic       mp;
    logic       mr;
    logic       rw;
    logic       mov;
    logic       mdrld;
    logic       marld;
    logic [5:0] opc;
    logic       cin;
    logic [1:0] sse;
    logic [3:0] op;
    logic [6:0] cr;
    logic       inv;
    logic       incrld;
    logic [1:0] s;
    logic [2:0] n;
  } cw_t;

  cw_t cw_q;
  logic cond_sel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cw_q <= '0;
    else        cw_q <= cw_t'(bus.StateSignals);
  end

  assign bus.IRld   = cw_q.irld;
  assign bus.PCld   = cw_q.pcld;
  assign bus.nPCld  = cw_q.npcld;
  assign bus.RFld   = cw_q.rfld;
  assign bus.MA     = cw_q.ma;
  assign bus.MB     = cw_q.mb;
  assign bus.MC     = cw_q.mc;
  assign bus.ME     = cw_q.me;
  assign bus.MF     = cw_q.mf;
  assign bus.MPA    = cw_q.mpa;
  assign bus.MP     = cw_q.mp;
  assign bus.MR     = cw_q.mr;
  assign bus.RW     = cw_q.rw;
  assign bus.MOV    = cw_q.mov;
  assign bus.MDRld  = cw_q.mdrld;
  assign bus.MARld  = cw_q.marld;
  assign bus.OpC    = cw_q.opc;
  assign bus.Cin    = cw_q.cin;
  assign bus.SSE    = cw_q.sse;
  assign bus.OP     = cw_q.op;
  assign bus.CR     = cw_q.cr;
  assign bus.Inv    = cw_q.inv;
  assign bus.IncRld = cw_q.incrld;
  assign bus.S      = cw_q.s;
  assign bus.N      = cw_q.n;

  // Condition stays un-inverted here; Inv is applied by the next-address logic.
  always_comb begin
    cond_sel = 1'b0;
    unique case (cw_q.s)
      2'b00:   cond_sel = bus.moc;
      2'b01:   cond_sel = bus.cond;
      2'b10:   cond_sel = bus.dmoc;
      default: cond_sel = 1'b0;
    endcase
  end

  assign bus.cond_out = cond_sel;

  // Wraps modulo 2**ADDR_W; the carry is deliberately dropped.
  assign bus.inc_out = bus.state_in + ADDR_W'(1);

endmodule

// File: tb/tb_ctrl_reg_cond_inc.sv
// Scoreboard bench for ctrl_reg_cond_inc: expected microwords and condition
// values are queued when driven and compared when the DUT presents them.
module tb_ctrl_reg_cond_inc;
  localparam int ADDR_W = 7;
  localparam int WORD_W = 44;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  logic [WORD_W-1:0] sb_word[$];
  logic              sb_bit[$];

  ctrl_reg_cond_inc_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

  ctrl_reg_cond_inc #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] obs_word();
    return {bus.IRld, bus.PCld, bus.nPCld, bus.RFld, bus.MA, bus.MB, bus.MC,
            bus.ME, bus.MF, bus.MPA, bus.MP, bus.MR, bus.RW, bus.MOV,
            bus.MDRld, bus.MARld, bus.OpC, bus.Cin, bus.SSE, bus.OP, bus.CR,
            bus.Inv, bus.IncRld, bus.S, bus.N};
  endfunction

  // Drive a word between edges, queue it, compare after the next edge.
  task automatic step(input logic [WORD_W-1:0] w);
    @(negedge clk);
    bus.StateSignals = w;
    sb_word.push_back(w);
    @(posedge clk);
    #1;
    chk("word", obs_word(), sb_word.pop_front());
  endtask

  task automatic cond_chk(input string tag, input logic m, input logic c,
                          input logic d, input logic exp);
    bus.moc = m; bus.cond = c; bus.dmoc = d;
    sb_bit.push_back(exp);
    #1;
    chk(tag, bus.cond_out, sb_bit.pop_front());
  endtask

  task automatic inc_chk(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] exp);
    bus.state_in = s;
    #1;
    chk("inc_out", bus.inc_out, exp);
  endtask

  initial begin
    logic [WORD_W-1:0] w;
    bus.StateSignals = '1;
    bus.moc = 1'b0; bus.cond = 1'b0; bus.dmoc = 1'b0;
    bus.state_in = '0;

    // Held in reset with all-ones input: fields stay zero, cond_out follows moc.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_word", obs_word(), '0);
    cond_chk("rst_moc1", 1'b1, 1'b1, 1'b1, 1'b1);
    cond_chk("rst_moc0", 1'b0, 1'b1, 1'b1, 1'b0);

    @(negedge clk);
    reset = 1'b1;
    step('1);
    chk("ones_opc", bus.OpC, 6'h3F);
    chk("ones_cr", bus.CR, 7'h7F);
    chk("ones_n", bus.N, 3'b111);

    step(44'h800_0000_0000);
    chk("only_irld", bus.IRld, 1'b1);
    chk("irld_n", bus.N, 3'b000);
    step(44'h000_0000_0001);
    chk("only_n_irld", bus.IRld, 1'b0);
    chk("only_n", bus.N, 3'b001);

    // CR=10, S=01: cond_out tracks cond combinationally.
    w = '0;
    w[13:7] = 7'd10;
    w[4:3]  = 2'b01;
    step(w);
    chk("cr10", bus.CR, 7'd10);
    chk("s01", bus.S, 2'b01);
    cond_chk("cond_hi", 1'b0, 1'b1, 1'b0, 1'b1);
    cond_chk("cond_lo", 1'b0, 1'b0, 1'b0, 1'b0);

    for (int s = 0; s < 4; s++) begin
      w = '0;
      w[4:3] = 2'(s);
      step(w);
      cond_chk($sformatf("sweep_s%0d", s), 1'b1, 1'b0, 1'b1, (s == 0 || s == 2));
      cond_chk($sformatf("sweep_inv_s%0d", s), 1'b0, 1'b1, 1'b0, (s == 1));
    end

    inc_chk(7'd0,   7'd1);
    inc_chk(7'd10,  7'd11);
    inc_chk(7'd126, 7'd127);
    inc_chk(7'd127, 7'd0);
    for (int i = 0; i < 6; i++) begin
      logic [ADDR_W-1:0] r;
      r = ADDR_W'($urandom_range(0, 127));
      inc_chk(r, ADDR_W'((int'(r) + 1) % 128));
    end

    for (int i = 0; i < 12; i++) begin
      w = {12'($urandom), 32'($urandom)};
      step(w);
    end

    // Asynchronous clear mid-cycle, checked before the next edge.
    step(44'hABC_DEF0_1234);
    #2;
    reset = 1'b0;
    #1;
    chk("async_clr", obs_word(), '0);
    chk("async_cr", bus.CR, 7'd0);
    cond_chk("async_moc", 1'b1, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("held_clr", obs_word(), '0);
    @(negedge clk);
    reset = 1'b1;
    step(44'h123_4567_89AB);

    chk("sb_empty", 64'(sb_word.size() + sb_bit.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/ctrl_reg_cond_inc.md
Name:
ctrl_reg_cond_inc

Overview:
Datapath slice of the microprogrammed control unit. It registers the 44-bit microinstruction word from the microstore and decodes it into individual control fields. It also selects the microbranch condition (moc / cond / dmoc) under the registered S field. Finally, it forms the incremented next-state address (current state + 1) for the incrementer register.

Parameters:
ADDR_W, 7, width of microstore state address / CR / incrementer path
WORD_W, 44, microinstruction width (fixed by field map; not meant to change)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low; 0 clears the control register
StateSignals  input  44  microinstruction word from microstore
moc  input  1  memory-operation-complete condition
cond  input  1  datapath branch condition
dmoc  input  1  second memory-complete condition
state_in  input  7  current state address (state-select mux output)
IRld, PCld, nPCld, RFld  output  1 each  register load enables
MA, MC, ME, MF, MPA, MP, MR  output  1 each  datapath mux selects
RW, MOV, MDRld, MARld  output  1 each  memory read/write, move, MDR/MAR loads
MB  output  2  operand-B mux select
OpC  output  6  ALU op code
Cin  output  1  ALU carry-in
SSE  output  2  sign/size extender control
OP  output  4  operation field
CR  output  7  microbranch target address
Inv  output  1  condition invert flag
IncRld  output  1  incrementer register load
S  output  2  condition-mux select
N  output  3  next-state-address selector code
cond_out  output  1  selected condition (pre-inversion)
inc_out  output  7  state_in + 1

Behaviour:
- Field map of the registered 44-bit word, bit 43 down to 0:
  - IRld 43, PCld 42, nPCld 41, RFld 40, MA 39, MB 38:37, MC 36, ME 35, MF 34, MPA 33, MP 32, MR 31, RW 30, MOV 29, MDRld 28, MARld 27.
  - OpC 26:21, Cin 20, SSE 19:18, OP 17:14, CR 13:7, Inv 6, IncRld 5, S 4:3, N 2:0.
- Control register:
  - Captures StateSignals on every rising clk.
  - No enable; one-cycle latency from StateSignals to the field outputs.
  - reset=0 asynchronously clears all 44 bits, so every field output reads 0.
  - Register stays cleared while reset is low and resumes capture on the first rising edge after reset returns high.
- All field outputs are direct slices of the register, with no extra logic.
- Condition mux is combinational on the registered S:
  - S=00 -> moc.
  - S=01 -> cond.
  - S=10 -> dmoc.
  - S=11 -> 0.
- Input changes on moc, cond or dmoc propagate to cond_out within the same cycle.
- Inv is output only; inversion is done downstream.
- Incrementer adder is purely combinational: inc_out = (state_in + 1) mod 128.
  - 127 wraps to 0.
  - No carry-out.
  - Unaffected by reset or clk.
- During reset, S=00, so cond_out follows moc.

Test Plan:
- reset=0 with StateSignals=all ones -> all field outputs 0, cond_out = moc; release reset, one clk edge -> every field all ones (OpC=6'h3F, CR=7'h7F, N=3'b111).
- StateSignals=44'h800_0000_0000 then 44'h000_0000_0001, one edge each -> first only IRld=1; then only N=3'b001.
- StateSignals with CR bits 13:7 = 7'd10, S=2'b01, cond=1, moc=0 -> after edge CR=10, S=01, cond_out=1; toggle cond to 0 -> cond_out=0 same cycle.
- Sweep S over 00/01/10/11 with moc=1, cond=0, dmoc=1 -> cond_out = 1/0/1/0.
- state_in = 0, 10, 126, 127 -> inc_out = 1, 11, 127, 0.
- Drop reset low between clk edges with fields non-zero -> outputs go 0 immediately, before the next edge.
